dmem_arbiter: RTL and testbench

Two-port arbiter that shares the byte-wide single-cycle data memory between the CPU load/store port (port 0) and the debug/loader port (port 1). Each 32-bit word request is serialised into four little-endian byte beats on the memory port, with round-robin fairness between requesters. Sits between the CPU datapath and the data memory; the CPU stalls on port 0 until `ack_o[0]`.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_rr_picker.sv | 19 +
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_t : arbiter FSM states
//   txn_t   : request fields latched at the grant edge
//   BEATS   : byte beats per 32-bit word
//   PORTS   : number of requesters
package dmem_arb_pkg;

  localparam int BEATS = 4;
  localparam int PORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  id;
    logic                  we;
    logic [BEATS-1:0][7:0] wdata;
  } txn_t;

endpackage

// File: rtl/dmem_rr_picker.sv
// Combinational two-way round-robin picker.
//   req      : per-port request
//   last_gnt : port served most recently
//   gnt_id   : winning port
//   gnt_vld  : any request present
module dmem_rr_picker
  import dmem_arb_pkg::*;
(
  input  logic [PORTS-1:0] req,
  input  logic             last_gnt,
  output logic             gnt_id,
  output logic             gnt_vld
);

  // On a tie the port that was not served last wins; otherwise the lone requester.
  assign gnt_vld = |req;
  assign gnt_id  = (&req) ? ~last_gnt : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter serialising 32-bit word accesses onto a byte-wide,
// single-cycle data memory as four little-endian beats.
//   clk_i, rst_i            : clock, async active-low reset
//   req_i, we_i             : per-port request / write enable
//   addr0_i, addr1_i        : per-port byte address ([1:0] ignored)
//   wdata0_i, wdata1_i      : per-port store data
//   ack_o                   : one-cycle completion pulse per port
//   rdata_o                 : load result, held until the next load completes
//   busy_o                  : FSM not idle
//   mem_addr_o/_wdata_o/_we_o, mem_rdata_i : byte memory port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PORTS-1:0]  req_i,
  input  logic [PORTS-1:0]  we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  output logic [PORTS-1:0]  ack_o,
  output logic [31:0]       rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  input  logic [7:0]        mem_rdata_i
);

  state_t            state;
  txn_t              txn;
  logic [1:0]        beat;
  logic [1:0]        beat_nxt;
  logic [ADDR_W-1:0] base;
  logic [23:0]       rbuf;
  logic              last_gnt;

  logic              gnt_id;
  logic              gnt_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [ADDR_W-1:0] sel_base;

  dmem_rr_picker u_pick (
    .req      (req_i),
    .last_gnt (last_gnt),
    .gnt_id   (gnt_id),
    .gnt_vld  (gnt_vld)
  );

  assign sel_addr  = gnt_id ? addr1_i  : addr0_i;
  assign sel_wdata = gnt_id ? wdata1_i : wdata0_i;
  assign sel_base  = sel_addr & ~ADDR_W'(3);
  assign beat_nxt  = beat + 2'd1;
  assign busy_o    = (state != IDLE);

  // Memory-side outputs are registered and advanced one edge ahead of each
  // beat, so nothing on the memory port depends combinationally on req_i.
  // Word-aligned base plus beat never carries past bit 1, so the beat
  // address is formed by replacing the low two bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      txn         <= '0;
      beat        <= '0;
      base        <= '0;
      rbuf        <= '0;
      last_gnt    <= 1'b1;
      ack_o       <= '0;
      rdata_o     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
    end else begin
      ack_o <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            txn.id      <= gnt_id;
            txn.we      <= we_i[gnt_id];
            txn.wdata   <= sel_wdata;
            base        <= sel_base;
            beat        <= '0;
            mem_addr_o  <= sel_base;
            mem_wdata_o <= sel_wdata[7:0];
            mem_we_o    <= we_i[gnt_id];
            state       <= XFER;
          end
        end
        XFER: begin
          // Load bytes shift in from the top; after three beats rbuf holds
          // bytes 2..0 and the fourth comes straight from the memory.
          if (!txn.we) rbuf <= {mem_rdata_i, rbuf[23:8]};
          if (beat == 2'(BEATS-1)) begin
            mem_we_o      <= 1'b0;
            ack_o[txn.id] <= 1'b1;
            if (!txn.we) rdata_o <= {mem_rdata_i, rbuf};
            state         <= ACK;
          end else begin
            beat        <= beat_nxt;
            mem_addr_o  <= {base[ADDR_W-1:2], beat_nxt};
            mem_wdata_o <= txn.wdata[beat_nxt];
          end
        end
        ACK: begin
          last_gnt <= txn.id;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 256-byte memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [31:0] addr0 = '0;
  logic [31:0] addr1 = '0;
  logic [31:0] wdata0 = '0;
  logic [31:0] wdata1 = '0;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_clr = 1'b0;
  logic [7:0]  mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .ack_o       (ack),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_clr = 1'b1;
    next_cycle();
    next_cycle();
    mem_clr = 1'b0;
    checks++;
    if (ack !== 2'b00 || rdata !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b rdata=%h busy=%b, need 00/00000000/0", ack, rdata, busy);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_mem_port: we=%b addr=%h wdata=%h, need 0/0/0", mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_store();
    logic [7:0] exp_b [4];
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    req = 2'b01; we = 2'b01; addr0 = 32'h08; wdata0 = 32'h11223344;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      checks++;
      if (mem_addr !== 32'(7 + k) || mem_wdata !== exp_b[k-1] || mem_we !== 1'b1 ||
          ack !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL store_beat%0d: addr=%h wdata=%h we=%b ack=%b busy=%b, need %h/%h/1/00/1",
                 k - 1, mem_addr, mem_wdata, mem_we, ack, busy, 32'(7 + k), exp_b[k-1]);
      end
    end
    next_cycle();
    checks++;
    if (ack !== 2'b01 || mem_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL store_ack: ack=%b we=%b busy=%b, need 01/0/1", ack, mem_we, busy);
    end
    req = 2'b00; we = 2'b00;
    next_cycle();
    checks++;
    if (ack !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL store_idle: ack=%b busy=%b, need 00/0", ack, busy);
    end
    checks++;
    if ({mem[11], mem[10], mem[9], mem[8]} !== 32'h11223344) begin
      errors++;
      $display("FAIL store_mem: got %h need 11223344", {mem[11], mem[10], mem[9], mem[8]});
    end
  endtask

  task automatic test_load();
    req = 2'b10; we = 2'b00; addr1 = 32'h0B;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      checks++;
      if (mem_addr !== 32'(7 + k) || mem_we !== 1'b0 || ack !== 2'b00) begin
        errors++;
        $display("FAIL load_beat%0d: addr=%h we=%b ack=%b, need %h/0/00",
                 k - 1, mem_addr, mem_we, ack, 32'(7 + k));
      end
    end
    next_cycle();
    checks++;
    if (ack !== 2'b10 || rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL load_ack: ack=%b rdata=%h, need 10/11223344", ack, rdata);
    end
    req = 2'b00;
    next_cycle();
    checks++;
    if (ack !== 2'b00 || rdata !== 32'h11223344 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_hold: ack=%b rdata=%h busy=%b, need 00/11223344/0", ack, rdata, busy);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [4];
    exp_b = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    req = 2'b01; we = 2'b01; addr0 = 32'hFFFF_FFFE; wdata0 = 32'hCAFEF00D;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      checks++;
      if (mem_addr !== (32'hFFFF_FFFB + 32'(k)) || mem_wdata !== exp_b[k-1] || mem_we !== 1'b1) begin
        errors++;
        $display("FAIL wrap_beat%0d: addr=%h wdata=%h we=%b, need %h/%h/1",
                 k - 1, mem_addr, mem_wdata, mem_we, 32'hFFFF_FFFB + 32'(k), exp_b[k-1]);
      end
    end
    next_cycle();
    checks++;
    if (ack !== 2'b01) begin
      errors++;
      $display("FAIL wrap_ack: ack=%b need 01", ack);
    end
    req = 2'b00; we = 2'b00;
    next_cycle();
    checks++;
    if (rdata !== 32'h11223344 || mem_addr !== 32'hFFFF_FFFF || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL wrap_hold: rdata=%h addr=%h we=%b, need 11223344/ffffffff/0", rdata, mem_addr, mem_we);
    end
    checks++;
    if ({mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]} !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL wrap_mem: got %h need cafef00d", {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]});
    end
  endtask

  task automatic test_reset_mid_xfer();
    req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'hAABBCCDD;
    for (int k = 1; k <= 3; k++) next_cycle();
    checks++;
    if (mem_addr !== 32'h22 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL abort_beat2: addr=%h we=%b, need 00000022/1", mem_addr, mem_we);
    end
    #1 rst = 1'b0;
    req = 2'b00; we = 2'b00;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || ack !== 2'b00) begin
      errors++;
      $display("FAIL abort_async: we=%b busy=%b ack=%b, need 0/0/00", mem_we, busy, ack);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 2) rst = 1'b1;
      checks++;
      if (ack !== 2'b00) begin
        errors++;
        $display("FAIL abort_no_ack: cycle %0d ack=%b need 00", k, ack);
      end
    end
    checks++;
    if ({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} !== 32'h0000CCDD) begin
      errors++;
      $display("FAIL abort_mem: got %h need 0000ccdd", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]});
    end
    req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'h55667788;
    for (int k = 1; k <= 5; k++) next_cycle();
    checks++;
    if (ack !== 2'b01) begin
      errors++;
      $display("FAIL abort_retry_ack: ack=%b need 01", ack);
    end
    req = 2'b00; we = 2'b00;
    next_cycle();
    checks++;
    if ({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} !== 32'h55667788) begin
      errors++;
      $display("FAIL abort_retry_mem: got %h need 55667788", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ack;
    logic [31:0] exp_addr;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    req = 2'b11; we = 2'b00; addr0 = 32'h40; addr1 = 32'h50;
    for (int c = 1; c <= 24; c++) begin
      next_cycle();
      exp_ack = 2'b00;
      if (c % 6 == 5) exp_ack = ((c / 6) % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL rr_ack: cycle %0d ack=%b need %b", c, ack, exp_ack);
      end
      if (c % 6 == 1) begin
        exp_addr = ((c / 6) % 2 == 0) ? 32'h40 : 32'h50;
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL rr_grant: cycle %0d addr=%h need %h", c, mem_addr, exp_addr);
        end
      end
    end
    req = 2'b00;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wrap();
    test_reset_mid_xfer();
    test_round_robin();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
